// File: rtl/td4_ctrl_pkg.sv
// td4_ctrl_pkg
// Shared definitions for the TD4 execution controller: FSM state encoding,
// operating-mode encodings, counter widths and a small mode helper.
package td4_ctrl_pkg;

  // Controller FSM states; the encoding is visible on the state output port.
  typedef enum logic [1:0] {
    ST_INIT    = 2'b00,
    ST_HALTED  = 2'b01,
    ST_RUNNING = 2'b10,
    ST_BRKED   = 2'b11
  } state_e;

  // Operating-mode encodings presented on the mode input.
  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_SLOW = 2'b10;
  localparam logic [1:0] MODE_FAST = 2'b11;

  // Counter widths.
  localparam int PRESC_W = 32;  // run-mode prescaler
  localparam int DEB_W   = 32;  // debounce stability counter
  localparam int RST_W   = 16;  // core reset hold counter
  localparam int INSTR_W = 8;   // issued-instruction counter

  // Both run modes have the MSB set, which is what distinguishes them from
  // HALT and STEP.
  function automatic logic is_run_mode(input logic [1:0] m);
    return m[1];
  endfunction

endpackage

// File: rtl/td4_debounce.sv
// td4_debounce
// Synchronises a raw push-button, accepts a level change only after it has
// been stable for DEB_CYCLES consecutive cycles, and emits a one-cycle pulse
// when an accepted change is a rising edge. Holding the button therefore
// produces exactly one pulse.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   raw         in   raw, bouncing button level (active-high)
//   press_pulse out  registered one-cycle pulse per accepted press
module td4_debounce
  import td4_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic press_pulse
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_r;
  logic             stable_r;
  logic [DEB_W-1:0] cnt_r;
  logic             press_r;

  logic             stable_nxt_s;
  logic [DEB_W-1:0] cnt_nxt_s;
  logic             press_nxt_s;

  // Stability counter: runs while the synchronised level differs from the
  // accepted level, restarts on any bounce back.
  always_comb begin
    stable_nxt_s = stable_r;
    cnt_nxt_s    = cnt_r;
    press_nxt_s  = 1'b0;
    if (sync_r[1] != stable_r) begin
      if (cnt_r == DEB_LAST) begin
        stable_nxt_s = sync_r[1];
        cnt_nxt_s    = '0;
        press_nxt_s  = sync_r[1];
      end else begin
        cnt_nxt_s = cnt_r + DEB_W'(1);
      end
    end else begin
      cnt_nxt_s = '0;
    end
  end

  // Synchroniser, accepted level, counter and pulse registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_r   <= 2'b00;
      stable_r <= 1'b0;
      cnt_r    <= '0;
      press_r  <= 1'b0;
    end else begin
      sync_r   <= {sync_r[0], raw};
      stable_r <= stable_nxt_s;
      cnt_r    <= cnt_nxt_s;
      press_r  <= press_nxt_s;
    end
  end

  assign press_pulse = press_r;

endmodule

// File: rtl/td4_exec_ctrl.sv
// td4_exec_ctrl
// Execution controller for a TD4 CPU core: holds the core in reset after
// power-up, then issues one-clock cpu_en pulses either per debounced step
// press or at a prescaled rate (slow/fast), honouring breakpoint requests.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   mode[1:0]  in   00 HALT, 01 STEP, 10 RUN_SLOW, 11 RUN_FAST
//   step_btn   in   raw push-button, active-high
//   brk        in   breakpoint/halt request from the core (level)
//   cpu_en     out  one-clock execute enable
//   cpu_rst_n  out  active-low core reset
//   state[1:0] out  FSM state (00 INIT, 01 HALTED, 10 RUNNING, 11 BRKED)
//   instr_cnt  out  cpu_en pulses since reset, wraps at 256
module td4_exec_ctrl
  import td4_ctrl_pkg::*;
#(
  parameter int unsigned SLOW_DIV   = 1000000,
  parameter int unsigned FAST_DIV   = 1000,
  parameter int unsigned DEB_CYCLES = 1000,
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       step_btn,
  input  logic       brk,
  output logic       cpu_en,
  output logic       cpu_rst_n,
  output logic [1:0] state,
  output logic [7:0] instr_cnt
);

  localparam logic [PRESC_W-1:0] SLOW_TC  = PRESC_W'(SLOW_DIV - 1);
  localparam logic [PRESC_W-1:0] FAST_TC  = PRESC_W'(FAST_DIV - 1);
  localparam logic [RST_W-1:0]   RST_LAST = RST_W'(RST_CYCLES - 1);

  state_e             state_r;
  logic [PRESC_W-1:0] presc_r;
  logic [RST_W-1:0]   rst_cnt_r;
  logic [1:0]         mode_q_r;
  logic               cpu_en_r;
  logic               cpu_rst_n_r;
  logic [INSTR_W-1:0] instr_cnt_r;

  state_e             state_nxt_s;
  logic [PRESC_W-1:0] presc_nxt_s;
  logic [RST_W-1:0]   rst_cnt_nxt_s;
  logic               cpu_rst_n_nxt_s;
  logic               pulse_s;
  logic               cpu_en_nxt_s;
  logic [INSTR_W-1:0] instr_cnt_nxt_s;

  logic               press_s;
  logic [PRESC_W-1:0] div_tc_s;
  logic               tc_s;
  logic               div_swap_s;

  td4_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clock      (clock),
    .reset      (reset),
    .raw        (step_btn),
    .press_pulse(press_s)
  );

  // Terminal count for the current run speed, and detection of a direct
  // slow<->fast switch (which restarts the prescaler without a pulse).
  always_comb begin
    div_tc_s   = (mode == MODE_FAST) ? FAST_TC : SLOW_TC;
    tc_s       = (presc_r == div_tc_s);
    div_swap_s = is_run_mode(mode) && is_run_mode(mode_q_r) && (mode != mode_q_r);
  end

  // Next-state and output decode. The terminal count is evaluated in the
  // cycle presc==DIV-1 and the pulse is registered, so the first pulse lands
  // exactly DIV edges after entering RUNNING; a breakpoint or halt seen in
  // that same cycle suppresses it.
  always_comb begin
    state_nxt_s     = state_r;
    presc_nxt_s     = '0;
    rst_cnt_nxt_s   = rst_cnt_r;
    cpu_rst_n_nxt_s = cpu_rst_n_r;
    pulse_s         = 1'b0;
    case (state_r)
      ST_INIT: begin
        cpu_rst_n_nxt_s = 1'b0;
        if (rst_cnt_r == RST_LAST) begin
          state_nxt_s     = ST_HALTED;
          cpu_rst_n_nxt_s = 1'b1;
          rst_cnt_nxt_s   = '0;
        end else begin
          rst_cnt_nxt_s = rst_cnt_r + RST_W'(1);
        end
      end
      ST_HALTED: begin
        if (is_run_mode(mode)) begin
          state_nxt_s = ST_RUNNING;
        end else if ((mode == MODE_STEP) && press_s) begin
          pulse_s = 1'b1;
        end else begin
          state_nxt_s = ST_HALTED;
        end
      end
      ST_RUNNING: begin
        // Step presses are deliberately dropped here, never queued.
        if (brk) begin
          state_nxt_s = ST_BRKED;
        end else if (!is_run_mode(mode)) begin
          state_nxt_s = ST_HALTED;
        end else if (div_swap_s) begin
          presc_nxt_s = '0;
        end else if (tc_s) begin
          pulse_s     = 1'b1;
          presc_nxt_s = '0;
        end else begin
          presc_nxt_s = presc_r + PRESC_W'(1);
        end
      end
      ST_BRKED: begin
        // A step with the breakpoint still asserted single-steps the core;
        // a step after it has cleared resumes to HALTED.
        if (press_s) begin
          if (brk) begin
            pulse_s = 1'b1;
          end else begin
            state_nxt_s = ST_HALTED;
          end
        end else begin
          state_nxt_s = ST_BRKED;
        end
      end
      default: begin
        state_nxt_s     = ST_INIT;
        cpu_rst_n_nxt_s = 1'b0;
        rst_cnt_nxt_s   = '0;
      end
    endcase

    // Never enable the core while it is in reset or on back-to-back cycles.
    cpu_en_nxt_s    = pulse_s && cpu_rst_n_r && !cpu_en_r;
    instr_cnt_nxt_s = cpu_en_nxt_s ? (instr_cnt_r + INSTR_W'(1)) : instr_cnt_r;
  end

  // Controller state and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_INIT;
      presc_r     <= '0;
      rst_cnt_r   <= '0;
      mode_q_r    <= MODE_HALT;
      cpu_en_r    <= 1'b0;
      cpu_rst_n_r <= 1'b0;
      instr_cnt_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      presc_r     <= presc_nxt_s;
      rst_cnt_r   <= rst_cnt_nxt_s;
      mode_q_r    <= mode;
      cpu_en_r    <= cpu_en_nxt_s;
      cpu_rst_n_r <= cpu_rst_n_nxt_s;
      instr_cnt_r <= instr_cnt_nxt_s;
    end
  end

  assign cpu_en    = cpu_en_r;
  assign cpu_rst_n = cpu_rst_n_r;
  assign state     = state_r;
  assign instr_cnt = instr_cnt_r;

endmodule

// File: tb/tb_td4_exec_ctrl.sv
// tb_td4_exec_ctrl
// Directed bench for td4_exec_ctrl with SLOW_DIV=8, FAST_DIV=3, DEB_CYCLES=4,
// RST_CYCLES=4. Stimulus pushes each expected cpu_en pulse (cycle window and
// instr_cnt value) into a scoreboard queue; a monitor pops and compares on
// every observed pulse. cyc counts rising edges; a pulse registered at edge N
// is seen by the monitor with cyc==N.
module tb_td4_exec_ctrl;

  logic       clock;
  logic       reset;
  logic [1:0] mode;
  logic       step_btn;
  logic       brk;
  logic       cpu_en;
  logic       cpu_rst_n;
  logic [1:0] state;
  logic [7:0] instr_cnt;

  typedef struct {
    int         lo;
    int         hi;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt = 8'd0;

  td4_exec_ctrl #(
    .SLOW_DIV  (8),
    .FAST_DIV  (3),
    .DEB_CYCLES(4),
    .RST_CYCLES(4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .mode     (mode),
    .step_btn (step_btn),
    .brk      (brk),
    .cpu_en   (cpu_en),
    .cpu_rst_n(cpu_rst_n),
    .state    (state),
    .instr_cnt(instr_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input int lo, input int hi);
    exp_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.lo  = lo;
    e.hi  = hi;
    e.cnt = exp_cnt;
    sb_q.push_back(e);
  endtask

  task automatic check_q_empty(input string name);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected pulses missing, first due at cycle %0d, now %0d",
               name, sb_q.size(), sb_q[0].lo, cyc);
    end
  endtask

  // Hold the button 20 cycles then release; optionally expect one pulse.
  task automatic press(input bit want_pulse);
    int t;
    t = cyc;
    if (want_pulse) expect_pulse(t + 1, t + 20);
    step_btn = 1'b1;
    tick(20);
    step_btn = 1'b0;
    tick(12);
  endtask

  // Called right after reset release: core reset held for exactly 4 edges.
  task automatic check_init(input string tag);
    tick(3);
    check({tag, "_rst_n_low"}, int'(cpu_rst_n), 0);
    check({tag, "_state_init"}, int'(state), 0);
    tick(1);
    check({tag, "_rst_n_high"}, int'(cpu_rst_n), 1);
    check({tag, "_state_halted"}, int'(state), 1);
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    logic prev_en;
    prev_en = 1'b0;
    forever begin
      @(negedge clock);
      if (cpu_en) begin
        checks++;
        if (!cpu_rst_n || prev_en) begin
          errors++;
          $display("FAIL pulse_rules: cpu_rst_n=%0d prev_cpu_en=%0d, required 1 and 0 (cycle %0d)",
                   cpu_rst_n, prev_en, cyc);
        end
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: cpu_en at cycle %0d instr_cnt=%0d, expected none",
                   cyc, instr_cnt);
        end else begin
          e = sb_q.pop_front();
          if (cyc < e.lo || cyc > e.hi) begin
            errors++;
            $display("FAIL pulse_time: cycle %0d, expected %0d..%0d", cyc, e.lo, e.hi);
          end
          checks++;
          if (instr_cnt != e.cnt) begin
            errors++;
            $display("FAIL pulse_instr_cnt: got %0d, expected %0d (cycle %0d)",
                     instr_cnt, e.cnt, cyc);
          end
        end
      end
      prev_en = cpu_en;
    end
  end

  initial begin
    int t0;
    int t1;
    reset    = 1'b0;
    mode     = 2'b00;
    step_btn = 1'b0;
    brk      = 1'b0;
    tick(2);
    check("reset_state", int'(state), 0);
    check("reset_rst_n", int'(cpu_rst_n), 0);
    check("reset_cpu_en", int'(cpu_en), 0);
    check("reset_instr_cnt", int'(instr_cnt), 0);

    // Power-up INIT sequence with mode HALT.
    reset = 1'b1;
    check_init("init");
    tick(4);

    // Single step with leading 2-cycle glitches.
    mode = 2'b01;
    tick(2);
    for (int g = 0; g < 2; g++) begin
      step_btn = 1'b1;
      tick(2);
      step_btn = 1'b0;
      tick(2);
    end
    press(1'b1);
    check("step_instr_cnt", int'(instr_cnt), 1);
    check("step_state", int'(state), 1);
    check_q_empty("step_q");

    // RUN_FAST: 10 pulses every 3 cycles, then switch to RUN_SLOW.
    mode = 2'b11;
    t0 = cyc;
    for (int k = 1; k <= 10; k++) expect_pulse(t0 + 1 + 3 * k, t0 + 1 + 3 * k);
    tick(31);
    check("fast_state", int'(state), 2);
    mode = 2'b10;
    t1 = cyc;
    expect_pulse(t1 + 9, t1 + 9);
    tick(9);
    mode = 2'b00;
    tick(3);
    check("run_halt_state", int'(state), 1);
    check("run_instr_cnt", int'(instr_cnt), 12);
    check_q_empty("run_q");

    // Breakpoint coinciding with the terminal count.
    mode = 2'b11;
    t0 = cyc;
    expect_pulse(t0 + 4, t0 + 4);
    tick(6);
    brk = 1'b1;
    tick(1);
    check("brk_state", int'(state), 3);
    mode = 2'b00;
    brk  = 1'b0;
    tick(10);
    check("brk_hold_state", int'(state), 3);
    brk = 1'b1;
    press(1'b1);
    check("brk_step_state", int'(state), 3);
    check("brk_step_cnt", int'(instr_cnt), 14);
    brk = 1'b0;
    press(1'b0);
    check("brk_resume_state", int'(state), 1);
    check_q_empty("brk_q");

    // Asynchronous reset in RUNNING_SLOW just before a pending pulse.
    mode = 2'b10;
    t0 = cyc;
    expect_pulse(t0 + 9, t0 + 9);
    tick(16);
    reset = 1'b0;
    #1;
    check("async_cpu_en", int'(cpu_en), 0);
    check("async_rst_n", int'(cpu_rst_n), 0);
    check("async_state", int'(state), 0);
    check("async_instr_cnt", int'(instr_cnt), 0);
    exp_cnt = 8'd0;
    mode = 2'b00;
    tick(3);
    reset = 1'b1;
    check_init("reinit");
    check_q_empty("reset_q");

    // 800 cycles of RUN_FAST: 266 pulses, counter wraps to 10. A step
    // press during the run must be ignored and not replayed afterwards.
    mode = 2'b11;
    t0 = cyc;
    for (int k = 1; k <= 266; k++) expect_pulse(t0 + 1 + 3 * k, t0 + 1 + 3 * k);
    tick(5);
    press(1'b0);
    tick(t0 + 800 - cyc);
    mode = 2'b01;
    tick(20);
    check("wrap_instr_cnt", int'(instr_cnt), 10);
    check("wrap_state", int'(state), 1);
    check_q_empty("wrap_q");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/td4_exec_ctrl.md
TD4_EXEC_CTRL -- requirements
Module: td4_exec_ctrl

Interface
REQ-001 SHALL have parameter SLOW_DIV, default 1000000, clock cycles between cpu_en pulses in RUN_SLOW (min 2).
REQ-002 SHALL have parameter FAST_DIV, default 1000, clock cycles between cpu_en pulses in RUN_FAST (min 2).
REQ-003 SHALL have parameter DEB_CYCLES, default 1000, stable cycles required to accept a step_btn level change.
REQ-004 SHALL have parameter RST_CYCLES, default 16, cycles cpu_rst_n is held low after reset release.
REQ-005 SHALL have port clock  in  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port mode  in  2  00 HALT, 01 STEP, 10 RUN_SLOW, 11 RUN_FAST (synchronous to clock).
REQ-008 SHALL have port step_btn  in  1  raw, bouncing push-button, active-high.
REQ-009 SHALL have port brk  in  1  breakpoint/halt request from the TD4 core, level.
REQ-010 SHALL have port cpu_en  out  1  one-clock enable pulse; core executes one instruction per pulse.
REQ-011 SHALL have port cpu_rst_n  out  1  active-low reset to the TD4 core.
REQ-012 SHALL have port state  out  2  current FSM state encoding.
REQ-013 SHALL have port instr_cnt  out  8  count of cpu_en pulses issued since reset.

Function
REQ-014 SHALL implement FSM states INIT(00), HALTED(01), RUNNING(10), BRKED(11).
REQ-015 INIT: cpu_rst_n=0 for RST_CYCLES cycles, then -> HALTED with cpu_rst_n=1 on the same edge.
REQ-016 HALTED: mode 10/11 -> RUNNING next cycle; mode 01 + accepted step press -> one cpu_en pulse, remain HALTED.
REQ-017 RUNNING: prescaler counts 0..DIV-1 (DIV per mode), cpu_en=1 in the cycle count==DIV-1, count wraps to 0.
REQ-018 RUNNING: first cpu_en SHALL occur exactly DIV cycles after entry.
REQ-019 RUNNING: mode 00 or 01 -> HALTED next cycle, no further cpu_en.
REQ-020 Mode change between RUN_SLOW and RUN_FAST SHALL clear the prescaler to 0 in the same cycle.
REQ-021 brk=1 in RUNNING -> BRKED next cycle; if brk and terminal count coincide, cpu_en SHALL NOT be issued.
REQ-022 BRKED: no cpu_en from prescaler; accepted step press with brk=0 -> HALTED (no pulse); step press with brk=1 -> one cpu_en pulse, stay BRKED.
REQ-023 Step press SHALL be recognised only on debounced rising edge: raw level stable DEB_CYCLES cycles, then one pulse; holding the button SHALL yield exactly one step.
REQ-024 Step presses in RUNNING or INIT SHALL be ignored (not queued).
REQ-025 cpu_en SHALL never be high in two consecutive cycles and never while cpu_rst_n=0.
REQ-026 instr_cnt SHALL increment by 1 on every cpu_en, wrap 255 -> 0.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 reset=0 SHALL immediately force: state=INIT, cpu_rst_n=0, cpu_en=0, instr_cnt=0, prescaler=0, debouncer state=0, reset counter=0.
REQ-029 reset asserted mid-RUNNING SHALL abort any pending pulse; after release the INIT sequence SHALL run in full.

Structure
REQ-030 Shared package td4_ctrl_pkg SHALL hold the state enum, mode encodings (MODE_HALT/STEP/SLOW/FAST) and counter widths.
REQ-031 Debounce + rising-edge detect SHALL be sub-module td4_debounce (params DEB_CYCLES; ports clock, reset, raw, press_pulse).

Verification (SLOW_DIV=8, FAST_DIV=3, DEB_CYCLES=4, RST_CYCLES=4)
REQ-032 Reset release, mode=00 -> cpu_rst_n rises after 4 cycles, state=01, no cpu_en.
REQ-033 mode=01, step_btn held high 20 cycles with 2-cycle glitches first -> exactly one cpu_en, instr_cnt=1.
REQ-034 mode=11 for 30 cycles -> cpu_en every 3rd cycle, 10 pulses, first at cycle 3; switch to 10 -> next pulse 8 cycles later.
REQ-035 RUNNING, brk=1 on terminal-count cycle -> no pulse, state=11; step with brk=0 -> state=01.
REQ-036 mode=11 for 800 cycles -> instr_cnt wraps past 255 to 10 (266 pulses).
REQ-037 reset=0 mid-RUNNING -> outputs zero asynchronously, INIT repeats, instr_cnt=0.
